dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory.
- Requester 0 is the CPU load/store port (c_*); requester 1 is the debug/DMA port (d_*).
- Accepts one request at a time via a valid/ready handshake and drives the memory's synchronous port.
- Returns read data or a write acknowledge to the granted requester with fixed latency.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 10, word-address width.
- DEPTH, 1024, number of implemented words; addresses >= DEPTH are out of range.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- c_req_valid  input  1  CPU request valid.
- c_req_we  input  1  CPU request is a write (1) or read (0).
- c_req_addr  input  ADDR_W  CPU word address.
- c_req_wdata  input  DATA_W  CPU write data.
- c_req_ready  output  1  CPU request accepted this cycle.
- c_rsp_valid  output  1  CPU response valid, one-cycle pulse.
- c_rsp_rdata  output  DATA_W  CPU read data.
- c_rsp_err  output  1  CPU address was out of range.
- d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err: same directions, widths and meanings for the DMA requester.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable; qualified by mem_en.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- Reset values: all outputs 0, including rdata and the internal latches.
- IDLE:
  - x_req_ready is combinational: 1 only for the arbitration winner, and only while in IDLE with that requester's valid high.
  - On handshake, latch winner id, we, addr and wdata, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (one cycle):
  - If the latched addr < DEPTH: mem_en=1, mem_we=latched we, mem_addr and mem_wdata driven from the latches.
  - If addr >= DEPTH: mem_en=0 and an internal error flag is set.
  - Always go to RESP.
- RESP (one cycle):
  - Winner's x_rsp_valid=1.
  - Read: x_rsp_rdata=mem_rdata.
  - Write or error: x_rsp_rdata=0.
  - x_rsp_err=error flag.
  - Go to IDLE.
- Registered response outputs: rsp_valid, rsp_rdata and rsp_err hold their values only during the RESP cycle and are 0 otherwise.
- The non-winning requester's rsp outputs stay 0.
- Latency: handshake in cycle n, mem_en in n+1, rsp_valid in n+2, next handshake possible in n+3. Peak throughput is one access per 3 cycles.
- Request stability: requesters must hold valid and payload until ready. The arbiter ignores payload changes after the handshake because the latched copy is used.
- Default arbitration, fixed priority: CPU wins whenever c_req_valid=1. DMA is granted only when c_req_valid=0.
- Simultaneous requests in IDLE: exactly one ready is asserted, never both.
- mem_en is never asserted outside ISSUE, so there is never more than one access in flight.
- Reset mid-transaction (RST in ISSUE or RESP): the state returns to IDLE immediately and the transaction is dropped with no response. A write in ISSUE may or may not have reached the memory; requesters must reissue.
- Address comparison is unsigned. With DEPTH = 2^ADDR_W the error path is unreachable, and that is legal.

Optional Feature:
- Macro: DM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Register last_grant is reset to 1 (DMA), so the CPU wins the first contest.
  - When both requesters are valid in IDLE, the one not equal to last_grant wins.
  - last_grant updates on every handshake; a single requester is always granted.
- Undefined: fixed CPU priority as in Behaviour. No last_grant register exists.

Test Plan:
- Reset, then drive nothing → all outputs 0, state IDLE; assert RST asynchronously mid-cycle → outputs 0 before the next edge.
- CPU write addr=5, wdata=32'h1234 → c_req_ready in cycle n; mem_en=1, mem_we=1, mem_addr=5 in n+1; c_rsp_valid=1, rdata=0, err=0 in n+2.
- CPU read addr=5 after that write, with memory model returning the stored value → c_rsp_rdata=32'h1234 in n+2; d_rsp_valid stays 0.
- DMA read addr=1024 with ADDR_W=11, DEPTH=1024 → mem_en stays 0; d_rsp_valid=1, d_rsp_err=1, d_rsp_rdata=0.
- Both requesters valid continuously for 4 transactions:
  - without DM_ARB_RR_EN → grants C,C,C,C;
  - with DM_ARB_RR_EN → grants C,D,C,D.
- RST pulsed during ISSUE of a DMA read → no d_rsp_valid; a new CPU request is accepted in the first IDLE cycle after reset release.

Source files
------------

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-requester arbiter/sequencer for the single-port data memory
//
// Ports:
//   CLK, RST            clock; asynchronous active-high reset
//   c_req_* / c_rsp_*   CPU requester (id 0): valid/we/addr/wdata -> ready; rsp valid/rdata/err
//   d_req_* / d_rsp_*   debug/DMA requester (id 1), same meaning as the CPU port
//   mem_en/we/addr/wdata synchronous memory port, driven only in ISSUE
//   mem_rdata           memory read data, valid the cycle after a read strobe
//
// Optional feature: define DM_ARB_RR_EN for round-robin arbitration between the
// two requesters; without it the CPU has fixed priority.
module dm_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              c_req_valid,
  input  logic              c_req_we,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [DATA_W-1:0] c_req_wdata,
  output logic              c_req_ready,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rsp_rdata,
  output logic              c_rsp_err,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdata,
  output logic              d_rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  // One extra bit so DEPTH == 2**ADDR_W is representable; compare is unsigned.
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;      // 0 = CPU, 1 = DMA
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;

  logic                grant_cpu, grant_dma;
  logic                out_of_range;
  logic                rsp_active;
  logic [DATA_W-1:0]   rsp_rdata;

  assign out_of_range = ({1'b0, addr_q} >= DEPTH_L);

`ifdef DM_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // On a contest the requester that did not win last time goes first.
  assign grant_dma = d_req_valid && (!c_req_valid || !last_grant_q);
`else
  assign grant_dma = d_req_valid && !c_req_valid;
`endif
  assign grant_cpu = c_req_valid && !grant_dma;

  assign c_req_ready = (state_q == IDLE) && grant_cpu;
  assign d_req_ready = (state_q == IDLE) && grant_dma;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef DM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (c_req_ready || d_req_ready) begin
          gnt_d   = d_req_ready;
          we_d    = d_req_ready ? d_req_we    : c_req_we;
          addr_d  = d_req_ready ? d_req_addr  : c_req_addr;
          wdata_d = d_req_ready ? d_req_wdata : c_req_wdata;
          err_d   = 1'b0;
`ifdef DM_ARB_RR_EN
          last_grant_d = d_req_ready;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        err_d   = out_of_range;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DM_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifdef DM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Memory port: only touched during ISSUE and only for in-range addresses.
  assign mem_en    = (state_q == ISSUE) && !out_of_range;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;

  // Valid and err come straight from state/err flops. Read data cannot be
  // registered: the memory only presents it during RESP, so it is passed
  // through, gated to zero outside RESP and for writes or errors.
  assign rsp_active = (state_q == RESP);
  assign rsp_rdata  = (rsp_active && !we_q && !err_q) ? mem_rdata : '0;

  assign c_rsp_valid = rsp_active && !gnt_q;
  assign c_rsp_err   = c_rsp_valid && err_q;
  assign c_rsp_rdata = gnt_q ? '0 : rsp_rdata;
  assign d_rsp_valid = rsp_active && gnt_q;
  assign d_rsp_err   = d_rsp_valid && err_q;
  assign d_rsp_rdata = gnt_q ? rsp_rdata : '0;

endmodule
